// File: rtl/fir_pkg.sv
// Shared types and helpers for the folded FIR filter.
// State encoding and accumulator width rule.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } fir_state_e;

    function automatic int acc_width(input int d, input int c, input int t);
        return d + c + $clog2(t);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiplier feeding a full-precision accumulator.
// clr_i zeroes both registers so a stale product never leaks into a new sum.
module fir_mac_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     mul_en_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic        [ACC_W-1:0]  acc_o
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] prod_ext;

    assign prod_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

    // Product is one stage ahead of the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (clr_i) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (mul_en_i) prod_q <= PW'(a_i) * PW'(b_i);
            if (acc_en_i) acc_q  <= acc_q + prod_ext;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_folded_mac.sv
// Time-multiplexed N-tap FIR: one shared MAC walks the taps in turn.
// Holds the control FSM, the sample delay line and the coefficient bank.
module fir_folded_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 6,
    parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      busy
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_L = (AW+1)'(TAPS);

    fir_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic accept, mul_en, acc_en, coef_ok;

    assign coef_ok = coef_we && !busy && ({1'b0, coef_addr} < TAPS_L);

    // Next state, tap counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        mul_en    = 1'b0;
        acc_en    = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mul_en = 1'b1;
                acc_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                acc_en  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and tap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Delay line: slot 0 is the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
        end else if (accept) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        end
    end

    // Coefficient bank; writes only land while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else if (coef_ok) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept),
        .mul_en_i (mul_en),
        .acc_en_i (acc_en),
        .a_i      (x_q[cnt_q]),
        .b_i      (coef_q[cnt_q]),
        .acc_o    (out_data)
    );

endmodule

// File: tb/tb_fir_folded_mac.sv
// Directed bench for fir_folded_mac: vector table plus
// hand-written sequences for backpressure, busy writes and reset.
module tb_fir_folded_mac;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [15:0] coef_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [34:0]       out_data;
    logic              busy;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic signed [15:0] smp;
        longint             exp;
    } vec_t;

    vec_t tbl [12];

    fir_folded_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // wmode: 0 none, 1 write on the accept cycle, 2 write during MAC
    task automatic apply(input logic signed [15:0] s, input int wmode,
                         input logic [2:0] wa, input logic signed [15:0] wd,
                         output longint y, output int lat);
        in_valid = 1'b1;
        in_data  = s;
        if (wmode == 1) begin
            coef_we = 1'b1; coef_addr = wa; coef_data = wd;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat      = 1;
        if (wmode == 2) begin
            coef_we = 1'b1; coef_addr = wa; coef_data = wd;
            @(posedge clk); #1;
            coef_we = 1'b0;
            lat++;
        end
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        y = longint'($signed(out_data));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 6; k++) write_coef(3'(k), 16'(k + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint y, y0;
        int lat;

        tbl = '{'{16'sd1, 1}, '{16'sd0, 2}, '{16'sd0, 3},
                '{16'sd0, 4}, '{16'sd0, 5}, '{16'sd0, 6},
                '{16'sd1, 1}, '{16'sd1, 3}, '{16'sd1, 6},
                '{16'sd1, 10}, '{16'sd1, 15}, '{16'sd1, 21}};

        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", longint'(in_ready), 1);
        check("rst out_valid", longint'(out_valid), 0);
        check("rst busy", longint'(busy), 0);
        check("rst out_data", longint'(out_data), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // impulse and step
        set_ramp();
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].smp, 0, 3'd0, 16'sd0, y, lat);
            check($sformatf("vec%0d out_data", i), y, tbl[i].exp);
            check($sformatf("vec%0d latency", i), longint'(lat), 8);
        end

        // extremes: history is six 1s, coefs all -32768
        for (int k = 0; k < 6; k++) write_coef(3'(k), 16'sh8000);
        for (int k = 0; k < 6; k++) begin
            apply(16'sh8000, 0, 3'd0, 16'sd0, y, lat);
            check($sformatf("extreme%0d", k), y,
                  longint'(k + 1) * 1073741824 - longint'(5 - k) * 32768);
        end
        check("extreme final", y, 64'sd6442450944);

        // backpressure with in_valid held high while busy
        set_ramp();
        in_valid = 1'b1;
        in_data  = 16'sd5;
        @(posedge clk); #1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", longint'(lat), 8);
        y0 = longint'($signed(out_data));
        check("bp out_data", y0, -655355);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp out_valid", longint'(out_valid), 1);
            check("bp stable", longint'($signed(out_data)), -655355);
            check("bp in_ready", longint'(in_ready), 0);
            check("bp busy", longint'(busy), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp idle in_ready", longint'(in_ready), 1);

        // coef write while busy is dropped; flush history to zero
        apply(16'sd0, 2, 3'd0, 16'sd99, y, lat);
        for (int k = 0; k < 5; k++) apply(16'sd0, 0, 3'd0, 16'sd0, y, lat);
        check("flush zero", y, 0);
        write_coef(3'd6, 16'sd50);
        apply(16'sd1, 0, 3'd0, 16'sd0, y, lat);
        check("busy write dropped", y, 1);

        // write on the accept cycle is used by this computation
        apply(16'sd0, 1, 3'd1, 16'sd7, y, lat);
        check("accept-cycle write", y, 7);

        // reset in the middle of MAC tap 3
        in_valid = 1'b1;
        in_data  = 16'sd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst in_ready", longint'(in_ready), 1);
        check("midrst busy", longint'(busy), 0);
        check("midrst out_data", longint'(out_data), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        apply(16'sd3, 0, 3'd0, 16'sd0, y, lat);
        check("coefs cleared", y, 0);
        set_ramp();
        apply(16'sd0, 0, 3'd0, 16'sd0, y, lat);
        check("delay line cleared", y, 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
